fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Read-side consumer for the async FIFO: sits in the read clock domain and pops words via rd_en/empty/data_out.
//  Absorbs the FIFO's 1-cycle read latency in a small prefetch buffer.
//  Re-presents the data as a valid/ready stream, with m_last framing every PKT_LEN words.
//  Adds enable/flush control and a word counter.
// PARAMETERS
//  DATA_WIDTH  8   width of FIFO data and stream data
//  BUF_DEPTH   3   prefetch buffer entries; >=2; 3 sustains 1 word/clk
//  PKT_LEN     16  words per packet; m_last on the last word; >=1
//  CNT_WIDTH   16  width of word_count
// PORTS
//  rd_clk      in   1           read-domain clock (only clock)
//  rd_rst      in   1           asynchronous reset, active-high
//  enable      in   1           1 = fetch from FIFO; 0 = stop fetching, buffer still drains
//  flush       in   1           1-cycle pulse: discard buffered/in-flight data, restart packet
//  fifo_empty  in   1           FIFO empty flag
//  fifo_data   in   DATA_WIDTH  FIFO data_out; valid the cycle after an accepted pop
//  fifo_rd_en  out  1           FIFO read enable
//  m_valid     out  1           stream word valid
//  m_ready     in   1           downstream ready
//  m_data      out  DATA_WIDTH  stream data
//  m_last      out  1           last word of packet
//  busy        out  1           state != IDLE
//  word_count  out  CNT_WIDTH   words delivered on stream, wraps
// BEHAVIOUR
//  Reset:
//   - all outputs 0, FSM=IDLE, buffer empty, in-flight 0, packet index 0.
//  Pop rule:
//   - fifo_rd_en = (state==ACTIVE) && (count + inflight < BUF_DEPTH).
//   - Built from registered state only; it must NOT depend on fifo_empty, because the FIFO's empty is combinational on rd_en.
//   - A pop is accepted when fifo_rd_en && !fifo_empty.
//   - On acceptance, inflight<=1 for exactly the next cycle.
//  Capture:
//   - In the cycle after acceptance, fifo_data is written into the buffer tail at the clock edge.
//  Stream:
//   - m_valid = count != 0; m_data = buffer head; transfer when m_valid && m_ready.
//   - m_data/m_last are held stable while m_valid && !m_ready.
//   - Capture and transfer may occur in the same cycle; count then stays unchanged.
//  Latency:
//   - Accepted pop at cycle N -> word visible on m_data at cycle N+2.
//  Framing:
//   - m_last = m_valid && (pkt_idx == PKT_LEN-1).
//   - pkt_idx increments on each transfer and wraps to 0 after the last word.
//   - PKT_LEN=1 -> every word is last.
//  word_count:
//   - +1 per transfer, modulo 2^CNT_WIDTH.
//  FSM:
//   - IDLE:   enable=1 -> ACTIVE.
//   - ACTIVE: enable=0 -> DRAIN.
//   - DRAIN:  no pops; count==0 && inflight==0 -> IDLE; enable=1 -> ACTIVE.
//   - FLUSH:  entered from any state on flush. Clears buffer and pkt_idx; word_count is kept.
//             The in-flight word (if any) is dropped on arrival. Exits when inflight==0:
//             to ACTIVE if enable, else IDLE.
//  Boundaries:
//   - fifo_empty=1 -> nothing accepted, no data captured.
//   - Buffer full -> fifo_rd_en=0.
//   - m_ready=0 for a long time -> buffer fills, pops stop, no word is lost.
//   - flush has priority over enable.
//   - Reset mid-transfer -> immediate clear; words already popped from the FIFO are lost (by design).
// STRUCTURE
//  - Shared package fifo_pkg: FSM state encoding (ST_IDLE, ST_ACTIVE, ST_DRAIN, ST_FLUSH) and the ptr-width function clog2.
//  - One sub-module, stream_prefetch_buf: BUF_DEPTH circular buffer with head/tail/count, push/pop, same-cycle push+pop.
//  - FSM, pop control, framing and counter live in the top.
// TESTING
//  1. FIFO preloaded with 0x00..0x0F, enable=1, m_ready=1
//     -> first m_valid 2 cycles after first pop, 16 consecutive beats 0x00..0x0F, m_last only on 0x0F, word_count=16.
//  2. m_ready toggles 1-0 randomly, 40 words
//     -> order preserved, m_data stable while stalled, fifo_rd_en never high when count+inflight==BUF_DEPTH.
//  3. fifo_empty=1 throughout with enable=1
//     -> m_valid stays 0, word_count=0, busy=1.
//  4. Hold m_ready=0 with 5 words in FIFO
//     -> exactly BUF_DEPTH words popped. Release -> remaining 2 follow, no loss.
//  5. flush in the cycle right after an accepted pop of 0xA5
//     -> 0xA5 never appears on m_data, pkt_idx restarts (next m_last after PKT_LEN words), word_count unchanged.
//  6. enable=0 mid-stream, then rd_rst pulse
//     -> DRAIN empties buffer then IDLE; rd_rst clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side stream logic: FSM encoding and width helper.
package fifo_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_FLUSH  = 2'd3;

    // Bits needed to index 0..value-1; never below 1 so degenerate sizes still give legal vectors.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/stream_prefetch_buf.sv
// Small circular prefetch buffer: head word readable combinationally, push and pop may share a cycle.
module stream_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int PTR_W      = clog2(DEPTH),
    parameter int CNT_W      = clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_push = i_push && !i_clr && ((r_count != CNT_W'(DEPTH)) || i_pop);
    assign w_pop  = i_pop && !i_clr && (r_count != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-domain consumer for the async FIFO: pops words, absorbs the read latency in a prefetch
// buffer and re-presents them as a valid/ready stream framed every PKT_LEN words.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int PKT_LEN    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int OCC_W = clog2(BUF_DEPTH + 1);
    localparam int IDX_W = clog2(PKT_LEN);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_inflight;
    logic [IDX_W-1:0]     r_pkt_idx;
    logic [CNT_WIDTH-1:0] r_word_count;
    logic [OCC_W-1:0]     w_count;
    logic [OCC_W:0]       w_occupancy;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_xfer;

    // Read enable comes from registered state only: the FIFO's empty flag depends on it combinationally.
    assign w_occupancy = {1'b0, w_count} + (OCC_W + 1)'(r_inflight);
    assign fifo_rd_en  = (r_state == ST_ACTIVE) && (w_occupancy < (OCC_W + 1)'(BUF_DEPTH));
    assign w_accept    = fifo_rd_en && !fifo_empty;

    // A word landing while a flush is requested or in progress belongs to the discarded stream.
    assign w_capture   = r_inflight && !flush && (r_state != ST_FLUSH);

    assign m_valid    = (w_count != '0);
    assign w_xfer     = m_valid && m_ready;
    assign m_last     = m_valid && (r_pkt_idx == IDX_W'(PKT_LEN - 1));
    assign busy       = (r_state != ST_IDLE);
    assign word_count = r_word_count;

    stream_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_prefetch (
        .i_clk       (rd_clk),
        .i_rst       (rd_rst),
        .i_clr       (flush),
        .i_push      (w_capture),
        .i_push_data (fifo_data),
        .i_pop       (w_xfer),
        .o_head_data (m_data),
        .o_count     (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) w_state_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!enable) w_state_next = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable) begin
                        w_state_next = ST_ACTIVE;
                    end else if ((w_count == '0) && !r_inflight) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (!r_inflight) w_state_next = enable ? ST_ACTIVE : ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state      <= ST_IDLE;
            r_inflight   <= 1'b0;
            r_pkt_idx    <= '0;
            r_word_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_accept;
            if (w_xfer) begin
                r_word_count <= r_word_count + CNT_WIDTH'(1);
            end
            if (flush) begin
                r_pkt_idx <= '0;
            end else if (w_xfer) begin
                r_pkt_idx <= (r_pkt_idx == IDX_W'(PKT_LEN - 1)) ? '0 : r_pkt_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO stand-in, queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BD = 3;
    localparam int PL = 16;
    localparam int CW = 16;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_FLUSH  = 3;

    logic          rd_clk     = 1'b0;
    logic          rd_rst     = 1'b1;
    logic          enable     = 1'b0;
    logic          flush      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          m_ready    = 1'b0;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_count;

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .PKT_LEN    (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 rd_clk = ~rd_clk;

    // Reference model: every popped-but-undelivered word with the cycle it becomes visible.
    typedef struct {
        logic [DW-1:0] d;
        int            avail;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    bit            force_empty = 1'b0;
    int            mode = M_IDLE;
    int            pkt  = 0;
    int            cyc  = 0;
    bit            prev_acc = 1'b0;
    logic [CW-1:0] wc = '0;

    bit s_rd_en, s_empty, s_xfer, s_flush, s_en;

    logic [DW-1:0] got_d[$];
    bit            got_l[$];
    int first_pop = -1, first_valid = -1, first_xfer = -1, last_xfer = -1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic refresh_empty();
        fifo_empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        first_pop   = -1;
        first_valid = -1;
        first_xfer  = -1;
        last_xfer   = -1;
    endtask

    task automatic update();
        bit            acc;
        int            pre_size;
        logic [DW-1:0] w;
        acc      = s_rd_en && !s_empty;
        pre_size = exp_q.size();
        w        = '0;
        if (s_xfer) begin
            exp_q.delete(0);
            wc  = wc + 1'b1;
            pkt = (pkt + 1) % PL;
        end
        if (acc) begin
            w         = fifo_q.pop_front();
            fifo_data = w;
        end
        if (s_flush) begin
            exp_q.delete();
            pkt = 0;
        end else if (acc) begin
            exp_q.push_back('{d: w, avail: cyc + 2});
        end
        if (s_flush) mode = M_FLUSH;
        else begin
            case (mode)
                M_IDLE:   if (s_en) mode = M_ACTIVE;
                M_ACTIVE: if (!s_en) mode = M_DRAIN;
                M_DRAIN: begin
                    if (s_en) mode = M_ACTIVE;
                    else if (pre_size == 0) mode = M_IDLE;
                end
                default:  if (!prev_acc) mode = s_en ? M_ACTIVE : M_IDLE;
            endcase
        end
        prev_acc = acc;
        cyc++;
        refresh_empty();
    endtask

    task automatic cycle();
        bit exp_valid;
        @(negedge rd_clk);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        chk("m_valid", m_valid, exp_valid);
        if (exp_valid) begin
            chk("m_data", m_data, exp_q[0].d);
            chk("m_last", m_last, pkt == PL - 1);
        end else begin
            chk("m_last", m_last, 0);
        end
        chk("fifo_rd_en", fifo_rd_en, (mode == M_ACTIVE) && (exp_q.size() < BD));
        chk("busy", busy, mode != M_IDLE);
        chk("word_count", word_count, wc);
        if (fifo_rd_en && !fifo_empty && first_pop < 0) first_pop = cyc;
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            $display("xfer cycle=%0d data=0x%02h last=%0b count=%0d", cyc, m_data, m_last, word_count);
        end
        s_rd_en = fifo_rd_en;
        s_empty = fifo_empty;
        s_xfer  = exp_valid && m_ready;
        s_flush = flush;
        s_en    = enable;
        @(posedge rd_clk);
        #1;
        update();
    endtask

    task automatic do_reset();
        rd_rst  = 1'b1;
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        rd_rst   = 1'b0;
        exp_q.delete();
        mode     = M_IDLE;
        pkt      = 0;
        wc       = '0;
        prev_acc = 1'b0;
        refresh_empty();
    endtask

    task automatic run_until(input int n, input int budget, input int ready_pct, input string name);
        int i;
        i = 0;
        while (got_d.size() < n && i < budget) begin
            m_ready = ($urandom_range(0, 99) < ready_pct);
            cycle();
            i++;
        end
        chk(name, got_d.size(), n);
    endtask

    initial begin
        logic [DW-1:0] src[$];
        logic [DW-1:0] b;
        int            guard;

        do_reset();
        chk("reset_valid", m_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", word_count, 0);

        // Preloaded FIFO streams back-to-back with one packet boundary.
        clear_log();
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        refresh_empty();
        enable = 1'b1;
        run_until(16, 100, 100, "t1_count");
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t1_data", got_d[i], i);
            chk("t1_last", got_l[i], i == 15);
        end
        chk("t1_latency", first_valid - first_pop, 2);
        chk("t1_back_to_back", last_xfer - first_xfer, 15);
        chk("t1_word_count", word_count, 16);

        // Random backpressure and FIFO gaps: order must be preserved.
        clear_log();
        src.delete();
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            src.push_back(b);
        end
        guard = 0;
        while (got_d.size() < 40 && guard < 600) begin
            m_ready     = $urandom_range(0, 1);
            force_empty = ($urandom_range(0, 4) == 0);
            refresh_empty();
            cycle();
            guard++;
        end
        force_empty = 1'b0;
        refresh_empty();
        chk("t2_count", got_d.size(), 40);
        for (int i = 0; i < got_d.size(); i++) chk("t2_order", got_d[i], src[i]);
        chk("t2_word_count", word_count, 56);

        // Empty FIFO while enabled.
        do_reset();
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (20) cycle();
        chk("t3_valid", m_valid, 0);
        chk("t3_word_count", word_count, 0);
        chk("t3_busy", busy, 1);

        // Stalled sink: buffer fills, then the rest follows without loss.
        do_reset();
        clear_log();
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'(8'h50 + i));
        refresh_empty();
        enable = 1'b1;
        repeat (20) cycle();
        chk("t4_popped", 5 - fifo_q.size(), 3);
        chk("t4_rd_en_off", fifo_rd_en, 0);
        chk("t4_head", m_data, 8'h50);
        run_until(5, 50, 100, "t4_count");
        for (int i = 0; i < got_d.size(); i++) chk("t4_data", got_d[i], 8'h50 + i);

        // Flush right after 0xA5 is popped: it and the word popped alongside the flush vanish.
        clear_log();
        fifo_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) fifo_q.push_back(8'(8'h10 + i));
        refresh_empty();
        m_ready = 1'b1;
        guard   = 0;
        while (!prev_acc && guard < 20) begin
            cycle();
            guard++;
        end
        chk("t5_pop_seen", prev_acc, 1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_word_count", word_count, 5);
        run_until(16, 100, 100, "t5_count");
        for (int i = 0; i < got_d.size(); i++) begin
            chk("t5_no_a5", got_d[i] == 8'hA5, 0);
            chk("t5_last", got_l[i], i == 15);
        end
        if (got_d.size() > 0) chk("t5_first", got_d[0], 8'h11);

        // Disable mid-stream: drain to idle, restart, then asynchronous reset.
        clear_log();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h60 + i));
        refresh_empty();
        repeat (6) begin
            m_ready = $urandom_range(0, 1);
            cycle();
        end
        enable = 1'b0;
        guard  = 0;
        while ((busy || m_valid) && guard < 200) begin
            m_ready = $urandom_range(0, 1);
            cycle();
            guard++;
        end
        chk("t6_idle", busy, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_rd_en", fifo_rd_en, 0);
        chk("t6_fifo_left", fifo_q.size() > 0, 1);
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (4) cycle();
        chk("t6_pre_valid", m_valid, 1);
        rd_rst = 1'b1;
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_last", m_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", word_count, 0);
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        do_reset();

        // Random mix of enable, flush, backpressure and FIFO gaps.
        clear_log();
        enable = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) enable = !enable;
            flush       = ($urandom_range(0, 24) == 0);
            m_ready     = ($urandom_range(0, 2) != 0);
            force_empty = ($urandom_range(0, 4) == 0);
            if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
            refresh_empty();
            cycle();
        end
        flush       = 1'b0;
        force_empty = 1'b0;
        enable      = 1'b0;
        m_ready     = 1'b1;
        refresh_empty();
        guard = 0;
        while ((busy || m_valid) && guard < 50) begin
            cycle();
            guard++;
        end
        chk("t7_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, checks);
        $fatal(1);
    end

endmodule
